bist_register_file_1r_1w: RTL and testbench
===========================================

BIST_REGISTER_FILE_1R_1W -- requirements
Module: bist_register_file_1r_1w

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning address bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width, a multiple of 8.
REQ-003 SHALL have parameter NUM_WORDS, default 2**ADDR_WIDTH, meaning implemented words, in the range 2 to 2**ADDR_WIDTH.
REQ-004 SHALL derive NUM_BYTE = DATA_WIDTH/8.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ReadEnable  in  1  functional read request.
- ReadAddr  in  ADDR_WIDTH  read address.
- ReadData  out  DATA_WIDTH  registered read data.
- WriteEnable  in  1  functional write request.
- WriteAddr  in  ADDR_WIDTH  write address.
- WriteData  in  NUM_BYTE x 8  write data.
- WriteBE  in  NUM_BYTE  byte enables.
- BistStart  in  1  start the March C- self-test.
- BistBusy  out  1  self-test running.
- BistDone  out  1  one-cycle pulse at completion.
- BistFail  out  1  sticky mismatch flag.
- BistFailAddr  out  ADDR_WIDTH  address of the first mismatch.

Function
REQ-006 SHALL store NUM_WORDS x DATA_WIDTH in a flop array; storage SHALL NOT be reset.
REQ-007 Functional write: when WriteEnable=1, BistBusy=0 and WriteAddr<NUM_WORDS, SHALL update bytes with WriteBE[i]=1 at the edge; out-of-range writes are ignored.
REQ-008 Functional read: when ReadEnable=1 and BistBusy=0, ReadData SHALL load word ReadAddr at the edge (1-cycle latency); it loads 0 if ReadAddr>=NUM_WORDS; it holds otherwise.
REQ-009 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-010 FSM states SHALL be IDLE, MARCH, DRAIN, DONE.
REQ-011 IDLE -> MARCH: on BistStart=1; on entry, BistFail and BistFailAddr SHALL clear to 0.
REQ-012 MARCH SHALL run six elements, one operation per cycle:
- M0 up: w0.
- M1 up: r0,w1.
- M2 up: r1,w0.
- M3 down: r0,w1.
- M4 down: r1,w0.
- M5 down: r0.
"0" means all-zeros and "1" means all-ones over the full word. "up" is 0..NUM_WORDS-1; "down" is NUM_WORDS-1..0.
REQ-013 Each BIST read SHALL be compared against its expected word one cycle later; after the final M5 read, MARCH -> DRAIN for that compare; DRAIN -> DONE.
REQ-014 BistBusy SHALL be 1 in MARCH and DRAIN, exactly 10*NUM_WORDS+1 cycles; DONE SHALL assert BistDone for one cycle and return to IDLE.
REQ-015 On a mismatch, BistFail SHALL set, and BistFailAddr SHALL capture the address only if BistFail was 0; both SHALL hold until the next start or reset.
REQ-016 While BistBusy=1, functional enables SHALL be ignored, ReadData SHALL hold, and BistStart SHALL be ignored.
REQ-017 BistStart in the DONE cycle SHALL be ignored.
REQ-018 After a passing run, every word SHALL read 0.

Reset
REQ-019 rst=1 SHALL force IDLE and set ReadData=0, BistBusy=0, BistDone=0, BistFail=0 and BistFailAddr=0 at the next edge; rst has priority over all inputs.
REQ-020 rst asserted mid-BIST SHALL abort the run immediately; no BistDone SHALL follow.

Verification
REQ-021 Directed functional test (NUM_WORDS=32): write 0xDEADBEEF to addr 3 with BE=4'b0101, after addr 3 held 0 -> read addr 3 returns 0x00AD00EF one cycle after ReadEnable.
REQ-022 Directed same-address test: addr 7 holds 0x11111111; same-cycle read and write of 0x22222222 to addr 7 -> read returns 0x11111111; the next read returns 0x22222222.
REQ-023 Directed BIST pass test (NUM_WORDS=32): pulse BistStart -> BistBusy high for 321 cycles, then BistDone pulses once with BistFail=0; all 32 words then read 0.
REQ-024 Directed fault test: force storage bit 0 of word 5 stuck-at-1, then run BIST -> BistFail=1 and BistFailAddr=5 at BistDone; functional writes issued during the run leave memory unchanged.
REQ-025 Directed reset test: rst asserted at cycle 100 of a BIST run -> all outputs 0 next cycle, no BistDone; a new BistStart then completes normally.
REQ-026 Directed range test (NUM_WORDS=20, ADDR_WIDTH=5): write to addr 25 is ignored; read of addr 25 returns 0; BIST busy time is 201 cycles.

Source files
------------

// File: rtl/bist_register_file_1r_1w.sv
// 1R/1W flop-based register file with byte-enable writes and a built-in
// March C- self-test engine that takes over the array while it runs.
module bist_register_file_1r_1w #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH,
    localparam int NUM_BYTE  = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ReadEnable,
    input  logic [ADDR_WIDTH-1:0]         ReadAddr,
    output logic [DATA_WIDTH-1:0]         ReadData,
    input  logic                          WriteEnable,
    input  logic [ADDR_WIDTH-1:0]         WriteAddr,
    input  logic [NUM_BYTE-1:0][7:0]      WriteData,
    input  logic [NUM_BYTE-1:0]           WriteBE,
    input  logic                          BistStart,
    output logic                          BistBusy,
    output logic                          BistDone,
    output logic                          BistFail,
    output logic [ADDR_WIDTH-1:0]         BistFailAddr
);

    typedef enum logic [1:0] {IDLE, MARCH, DRAIN, DONE} state_t;

    localparam int unsigned             NW_U      = NUM_WORDS;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem;

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic                    phase_q, phase_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    single, down, bist_re, bist_we, exp_ones, wr_ones;

    logic                    cmp_valid_q, cmp_ones_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic [DATA_WIDTH-1:0]   cmp_data_q;
    logic                    mismatch;
    logic                    start;

    assign BistBusy = (state_q == MARCH) || (state_q == DRAIN);
    assign BistDone = (state_q == DONE);
    assign start    = (state_q == IDLE) && BistStart;
    assign mismatch = cmp_valid_q && (cmp_data_q != (cmp_ones_q ? '1 : '0));

    // Elements 0 and 5 are single-op; elements 1-4 alternate read (phase 0)
    // then write (phase 1) at each address before stepping.
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        single   = 1'b0;
        down     = 1'b0;
        bist_re  = 1'b0;
        bist_we  = 1'b0;
        exp_ones = 1'b0;
        wr_ones  = 1'b0;
        case (state_q)
            IDLE: begin
                if (BistStart) begin
                    state_d = MARCH;
                    elem_d  = '0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                end
            end
            MARCH: begin
                single   = (elem_q == 3'd0) || (elem_q == 3'd5);
                down     = (elem_q >= 3'd3);
                bist_re  = (elem_q != 3'd0) && !phase_q;
                bist_we  = (elem_q != 3'd5) && (single || phase_q);
                exp_ones = (elem_q == 3'd2) || (elem_q == 3'd4);
                wr_ones  = (elem_q == 3'd1) || (elem_q == 3'd3);
                if (single || phase_q) begin
                    phase_d = 1'b0;
                    if (down ? (addr_q == '0) : (addr_q == LAST_ADDR)) begin
                        if (elem_q == 3'd5) begin
                            state_d = DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = (elem_q >= 3'd2) ? LAST_ADDR : '0;
                        end
                    end else begin
                        addr_d = down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= '0;
            phase_q      <= 1'b0;
            addr_q       <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_ones_q   <= 1'b0;
            cmp_addr_q   <= '0;
            cmp_data_q   <= '0;
            BistFail     <= 1'b0;
            BistFailAddr <= '0;
            ReadData     <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            cmp_valid_q <= bist_re;
            cmp_ones_q  <= exp_ones;
            cmp_addr_q  <= addr_q;
            if (bist_re)
                cmp_data_q <= mem[addr_q];
            if (start) begin
                BistFail     <= 1'b0;
                BistFailAddr <= '0;
            end else if (mismatch) begin
                BistFail <= 1'b1;
                if (!BistFail)
                    BistFailAddr <= cmp_addr_q;
            end
            if (ReadEnable && !BistBusy)
                ReadData <= (32'(ReadAddr) < NW_U) ? mem[ReadAddr] : '0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bist_we) begin
                mem[addr_q] <= wr_ones ? '1 : '0;
            end else if (WriteEnable && !BistBusy && (32'(WriteAddr) < NW_U)) begin
                for (int unsigned i = 0; i < NUM_BYTE; i++)
                    if (WriteBE[i])
                        mem[WriteAddr][i*8 +: 8] <= WriteData[i];
            end
        end
    end

endmodule

// File: tb/tb_bist_register_file_1r_1w.sv
// Directed bench: a 32-word and a 20-word instance share all inputs; checks
// use hand-computed values.
module tb_bist_register_file_1r_1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0, bs = 1'b0;
    logic [4:0]  ra = '0, wa = '0;
    logic [31:0] wd = '0;
    logic [3:0]  be = '0;

    logic [31:0] rd, rd2;
    logic        busy, done, fail, busy2, done2, fail2;
    logic [4:0]  faddr, faddr2;

    int checks = 0;
    int errors = 0;

    int          busy_cnt, busy2_cnt, done_cnt, done2_cnt;
    logic        fail_done, fail2_done, traffic;
    logic [4:0]  faddr_done;

    bist_register_file_1r_1w dut (
        .clk(clk), .rst(rst),
        .ReadEnable(re), .ReadAddr(ra), .ReadData(rd),
        .WriteEnable(we), .WriteAddr(wa), .WriteData(wd), .WriteBE(be),
        .BistStart(bs), .BistBusy(busy), .BistDone(done),
        .BistFail(fail), .BistFailAddr(faddr)
    );

    bist_register_file_1r_1w #(.NUM_WORDS(20)) dut20 (
        .clk(clk), .rst(rst),
        .ReadEnable(re), .ReadAddr(ra), .ReadData(rd2),
        .WriteEnable(we), .WriteAddr(wa), .WriteData(wd), .WriteBE(be),
        .BistStart(bs), .BistBusy(busy2), .BistDone(done2),
        .BistFail(fail2), .BistFailAddr(faddr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; wa = a; wd = d; be = m;
        tick();
        we = 1'b0;
    endtask

    task automatic read_word(input logic [4:0] a);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0;
    endtask

    // Start a run and observe a fixed window; a BistStart is re-issued in the
    // 20-word instance's DONE cycle (and while the 32-word one is busy).
    task automatic run_bist(input int window);
        busy_cnt = 0; busy2_cnt = 0; done_cnt = 0; done2_cnt = 0;
        fail_done = 1'b0; fail2_done = 1'b0; faddr_done = '0;
        bs = 1'b1;
        tick();
        for (int i = 0; i < window; i++) begin
            if (busy)  busy_cnt++;
            if (busy2) busy2_cnt++;
            if (done)  begin done_cnt++;  fail_done = fail; faddr_done = faddr; end
            if (done2) begin done2_cnt++; fail2_done = fail2; end
            bs = done2;
            re = traffic && busy; ra = 5'd7;
            we = traffic && busy; wa = 5'd2; wd = 32'hFFFF_FFFF; be = 4'hF;
            tick();
        end
        bs = 1'b0; re = 1'b0; we = 1'b0;
    endtask

    initial begin
        traffic = 1'b0;
        tick();
        check("rst_readdata", rd, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_failaddr", faddr, 0);
        rst = 1'b0;

        write_word(5'd3, 32'h0, 4'hF);
        write_word(5'd3, 32'hDEAD_BEEF, 4'b0101);
        read_word(5'd3);
        check("be_merge", rd, 32'h00AD_00EF);
        check("be_merge_20", rd2, 32'h00AD_00EF);
        ra = 5'd0;
        tick();
        check("read_hold", rd, 32'h00AD_00EF);

        write_word(5'd7, 32'h1111_1111, 4'hF);
        re = 1'b1; ra = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h2222_2222; be = 4'hF;
        tick();
        we = 1'b0;
        check("same_addr_old", rd, 32'h1111_1111);
        tick();
        re = 1'b0;
        check("same_addr_new", rd, 32'h2222_2222);

        write_word(5'd25, 32'h1234_5678, 4'hF);
        read_word(5'd25);
        check("range_read_20", rd2, 32'h0);
        check("range_read_32", rd, 32'h1234_5678);

        run_bist(340);
        check("pass_busy_cycles", busy_cnt, 321);
        check("pass_busy_cycles_20", busy2_cnt, 201);
        check("pass_done_pulses", done_cnt, 1);
        check("pass_done_pulses_20", done2_cnt, 1);
        check("pass_fail", fail_done, 0);
        check("pass_fail_20", fail2_done, 0);
        for (int i = 0; i < 32; i++) begin
            read_word(5'(i));
            check($sformatf("zero_word_%0d", i), rd, 32'h0);
            if (i < 20) check($sformatf("zero_word20_%0d", i), rd2, 32'h0);
        end

        write_word(5'd7, 32'h5A5A_5A5A, 4'hF);
        read_word(5'd7);
        check("pre_fault_read", rd, 32'h5A5A_5A5A);
        force dut.mem[5][0] = 1'b1;
        traffic = 1'b1;
        run_bist(340);
        traffic = 1'b0;
        check("fault_done_pulses", done_cnt, 1);
        check("fault_fail", fail_done, 1);
        check("fault_addr", faddr_done, 5);
        check("fault_fail_20", fail2_done, 0);
        check("busy_read_hold", rd, 32'h5A5A_5A5A);
        read_word(5'd2);
        check("busy_write_ignored", rd, 32'h0);

        write_word(5'd9, 32'hA5A5_A5A5, 4'hF);
        read_word(5'd9);
        check("pre_rst_read", rd, 32'hA5A5_A5A5);
        bs = 1'b1;
        tick();
        bs = 1'b0;
        repeat (100) tick();
        check("mid_run_busy", busy, 1);
        check("mid_run_fail", fail, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_readdata", rd, 32'h0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_fail", fail, 0);
        check("abort_failaddr", faddr, 0);
        done_cnt = 0;
        for (int i = 0; i < 250; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        release dut.mem[5][0];

        run_bist(340);
        check("rerun_busy_cycles", busy_cnt, 321);
        check("rerun_done_pulses", done_cnt, 1);
        check("rerun_fail", fail_done, 0);
        read_word(5'd5);
        check("rerun_word5", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
